// File: rtl/sne_evt_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sne_evt_stream_pkg
// Description : Shared types and the saturating-add helper for the event
//               stream lanes.
// Revision    : 1.0 - initial release
// ============================================================================
package sne_evt_stream_pkg;

    localparam int STATE_DATA_WIDTH = 16;
    localparam int WEIGHT_WIDTH     = 8;

    typedef logic signed [STATE_DATA_WIDTH-1:0] state_t;
    typedef logic signed [WEIGHT_WIDTH-1:0]     weight_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        CLR_WAIT = 2'd1,
        CLR      = 2'd2
    } lane_fsm_e;

    // State plus sign-extended weight, clamped to the signed state range.
    function automatic state_t sat_add(input state_t s, input weight_t w);
        logic signed [STATE_DATA_WIDTH:0] wide;
        wide = {s[STATE_DATA_WIDTH-1], s}
             + {{(STATE_DATA_WIDTH+1-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
        if (wide[STATE_DATA_WIDTH] != wide[STATE_DATA_WIDTH-1]) begin
            sat_add = wide[STATE_DATA_WIDTH] ? {1'b1, {(STATE_DATA_WIDTH-1){1'b0}}}
                                             : {1'b0, {(STATE_DATA_WIDTH-1){1'b1}}};
        end else begin
            sat_add = wide[STATE_DATA_WIDTH-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/evt_sat_add_cmp.sv
`default_nettype none
// ============================================================================
// Module      : evt_sat_add_cmp
// Description : Combinational saturating add of a signed weight onto a
//               signed neuron state, plus signed threshold compare.
// Revision    : 1.0 - initial release
// ============================================================================
module evt_sat_add_cmp
    import sne_evt_stream_pkg::*;
#(
    parameter int STATE_DATA_WIDTH = 16,
    parameter int WEIGHT_WIDTH     = 8
) (
    input  logic signed [STATE_DATA_WIDTH-1:0] state_i,
    input  logic signed [WEIGHT_WIDTH-1:0]     weight_i,
    input  logic signed [STATE_DATA_WIDTH-1:0] threshold_i,
    output logic signed [STATE_DATA_WIDTH-1:0] sum_o,
    output logic                               fire_o
);

    localparam int SDW = STATE_DATA_WIDTH;
    localparam int WW  = WEIGHT_WIDTH;

    generate
        if (SDW == sne_evt_stream_pkg::STATE_DATA_WIDTH &&
            WW  == sne_evt_stream_pkg::WEIGHT_WIDTH) begin : g_pkg_width
            // Widths match the package types: reuse the shared helper.
            always_comb sum_o = sat_add(state_i, weight_i);
        end else begin : g_generic_width
            logic signed [SDW:0] w_wide;
            // Same clamp as the helper, sized from the parameters.
            always_comb begin
                w_wide = {state_i[SDW-1], state_i} + {{(SDW+1-WW){weight_i[WW-1]}}, weight_i};
                if (w_wide[SDW] != w_wide[SDW-1]) begin
                    sum_o = w_wide[SDW] ? {1'b1, {(SDW-1){1'b0}}} : {1'b0, {(SDW-1){1'b1}}};
                end else begin
                    sum_o = w_wide[SDW-1:0];
                end
            end
        end
    endgenerate

    // Signed compare: both operands are declared signed.
    assign fire_o = (sum_o >= threshold_i);

endmodule
`default_nettype wire

// File: rtl/evt_state_update_lane.sv
`default_nettype none
// ============================================================================
// Module      : evt_state_update_lane
// Description : Read-modify-write integration of synaptic events into the
//               banked neuron state memory, with spike output and clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module evt_state_update_lane
    import sne_evt_stream_pkg::*;
#(
    parameter int NEURONS_ADDR_WIDTH = 12,
    parameter int STATE_DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH       = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    output logic                          busy_o,
    input  logic [STATE_DATA_WIDTH-1:0]   threshold_i,
    input  logic                          evt_valid_i,
    output logic                          evt_ready_o,
    input  logic [NEURONS_ADDR_WIDTH-1:0] evt_addr_i,
    input  logic [WEIGHT_WIDTH-1:0]       evt_weight_i,
    output logic                          spk_valid_o,
    input  logic                          spk_ready_i,
    output logic [NEURONS_ADDR_WIDTH-1:0] spk_addr_o,
    output logic                          rd_en_o,
    output logic [NEURONS_ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [STATE_DATA_WIDTH-1:0]   rd_data_i,
    output logic                          wr_en_o,
    output logic [NEURONS_ADDR_WIDTH-1:0] wr_addr_o,
    output logic [STATE_DATA_WIDTH-1:0]   wr_data_o,
    output logic                          group_clk_en_o
);

    localparam int NAW = NEURONS_ADDR_WIDTH;
    localparam int SDW = STATE_DATA_WIDTH;
    localparam int WW  = WEIGHT_WIDTH;

    lane_fsm_e          state_q, state_d;
    logic [NAW-1:0]     cnt_q, cnt_d;

    logic               s1_valid_q;
    logic               s1_first_q;
    logic [NAW-1:0]     s1_addr_q;
    logic [WW-1:0]      s1_weight_q;
    logic [SDW-1:0]     hold_q;

    logic               spk_valid_q;
    logic [NAW-1:0]     spk_addr_q;

    logic [SDW-1:0]     w_state;
    logic [SDW-1:0]     w_sum;
    logic               w_fire;
    logic               w_commit;
    logic               w_stall;
    logic               w_accept;
    logic               w_sweep;

    // The read data is only valid the cycle after the read; stalls reuse the hold copy.
    assign w_state = s1_first_q ? rd_data_i : hold_q;

    evt_sat_add_cmp #(
        .STATE_DATA_WIDTH (SDW),
        .WEIGHT_WIDTH     (WW)
    ) u_sat_add_cmp (
        .state_i     (w_state),
        .weight_i    (s1_weight_q),
        .threshold_i (threshold_i),
        .sum_o       (w_sum),
        .fire_o      (w_fire)
    );

    assign w_commit = s1_valid_q & (~w_fire | ~spk_valid_q | spk_ready_i);
    assign w_stall  = s1_valid_q & ~w_commit;
    assign w_sweep  = (state_q == CLR);

    // A clear request also blocks acceptance so the sweep never meets a live stage 1.
    assign evt_ready_o = (state_q == RUN) & ~clear_i & ~w_stall
                       & ~(s1_valid_q & (evt_addr_i[0] == s1_addr_q[0]));
    assign w_accept    = evt_valid_i & evt_ready_o;

    assign rd_en_o   = w_accept;
    assign rd_addr_o = w_accept ? evt_addr_i : '0;

    assign wr_en_o   = w_sweep | w_commit;
    assign wr_addr_o = w_sweep ? cnt_q : (w_commit ? s1_addr_q : '0);
    assign wr_data_o = (w_commit & ~w_fire) ? w_sum : '0;

    assign busy_o         = (state_q != RUN);
    assign spk_valid_o    = spk_valid_q;
    assign spk_addr_o     = spk_addr_q;
    assign group_clk_en_o = rd_en_o | wr_en_o | s1_valid_q;

    // FSM and sweep counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: wait for stage 1 to drain before sweeping; sweep wraps back to 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (clear_i) state_d = s1_valid_q ? CLR_WAIT : CLR;
            end
            CLR_WAIT: begin
                if (!s1_valid_q) state_d = CLR;
            end
            CLR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {NAW{1'b1}}) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Stage 1 register: loaded on accept, emptied on commit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_weight_q <= '0;
            hold_q      <= '0;
        end else begin
            s1_first_q <= w_accept;
            if (s1_first_q) hold_q <= rd_data_i;
            if (w_accept) begin
                s1_valid_q  <= 1'b1;
                s1_addr_q   <= evt_addr_i;
                s1_weight_q <= evt_weight_i;
            end else if (w_commit) begin
                s1_valid_q  <= 1'b0;
            end
        end
    end

    // Single-entry spike register; a new spike may replace one draining this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            spk_valid_q <= 1'b0;
            spk_addr_q  <= '0;
        end else if (w_commit & w_fire) begin
            spk_valid_q <= 1'b1;
            spk_addr_q  <= s1_addr_q;
        end else if (spk_ready_i) begin
            spk_valid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_evt_state_update_lane.sv
`default_nettype none
// ============================================================================
// Module      : tb_evt_state_update_lane
// Description : Directed self-checking bench for evt_state_update_lane with a
//               small behavioural state memory (NAW = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_evt_state_update_lane;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        busy_o;
    logic [15:0] threshold_i;
    logic        evt_valid_i;
    logic        evt_ready_o;
    logic [3:0]  evt_addr_i;
    logic [7:0]  evt_weight_i;
    logic        spk_valid_o;
    logic        spk_ready_i;
    logic [3:0]  spk_addr_o;
    logic        rd_en_o;
    logic [3:0]  rd_addr_o;
    logic [15:0] rd_data_i;
    logic        wr_en_o;
    logic [3:0]  wr_addr_o;
    logic [15:0] wr_data_o;
    logic        group_clk_en_o;

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
        int          c;
    } wr_t;
    wr_t wr_log[$];

    logic [15:0] mem [16];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    always #5 clk = ~clk;

    evt_state_update_lane #(
        .NEURONS_ADDR_WIDTH (4),
        .STATE_DATA_WIDTH   (16),
        .WEIGHT_WIDTH       (8)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .clear_i        (clear_i),
        .busy_o         (busy_o),
        .threshold_i    (threshold_i),
        .evt_valid_i    (evt_valid_i),
        .evt_ready_o    (evt_ready_o),
        .evt_addr_i     (evt_addr_i),
        .evt_weight_i   (evt_weight_i),
        .spk_valid_o    (spk_valid_o),
        .spk_ready_i    (spk_ready_i),
        .spk_addr_o     (spk_addr_o),
        .rd_en_o        (rd_en_o),
        .rd_addr_o      (rd_addr_o),
        .rd_data_i      (rd_data_i),
        .wr_en_o        (wr_en_o),
        .wr_addr_o      (wr_addr_o),
        .wr_data_o      (wr_data_o),
        .group_clk_en_o (group_clk_en_o)
    );

    // Memory: 1-cycle read latency, garbage when not read so stalls must use the hold copy.
    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (rd_en_o) rd_data_i <= mem[rd_addr_o];
        else         rd_data_i <= 16'hDEAD;
        if (wr_en_o)      mem[wr_addr_o] <= wr_data_o;
        else if (pre_en)  mem[pre_addr]  <= pre_data;
    end

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en_o === 1'b1) wr_log.push_back('{wr_addr_o, wr_data_o, cyc_n});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Present one event and hold it until accepted; returns stall count (99 on timeout).
    task automatic send(input logic [3:0] a, input logic [7:0] w, output int stalls);
        evt_valid_i  = 1'b1;
        evt_addr_i   = a;
        evt_weight_i = w;
        stalls       = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (evt_ready_o) break;
            stalls++;
        end
        if (stalls >= 50) stalls = 99;
        @(posedge clk);
        #1;
        evt_valid_i = 1'b0;
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        cyc();
        pre_en = 1'b0;
    endtask

    task automatic test_reset();
        n_vec++;
        if ({wr_en_o, rd_en_o, spk_valid_o, busy_o, group_clk_en_o, evt_ready_o} !== 6'b000001) begin
            n_err++;
            $display("FAIL reset_outputs: got wr,rd,spk,busy,gce,rdy=%b required 000001",
                     {wr_en_o, rd_en_o, spk_valid_o, busy_o, group_clk_en_o, evt_ready_o});
        end
    endtask

    task automatic test_clear();
        int cnt;
        cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy_o !== 1'b1) break;
            n_vec++;
            if (!(wr_en_o === 1'b1 && wr_addr_o === cnt[3:0] && wr_data_o === 16'd0)) begin
                n_err++;
                $display("FAIL clear_write: got en=%b addr=%0d data=%h required en=1 addr=%0d data=0000",
                         wr_en_o, wr_addr_o, wr_data_o, cnt);
            end
            cnt++;
        end
        n_vec++;
        if (cnt != 16) begin
            n_err++;
            $display("FAIL clear_length: got %0d busy cycles required 16", cnt);
        end
        n_vec++;
        if (wr_en_o !== 1'b0 || evt_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL clear_exit: got wr_en=%b ready=%b required 0 1", wr_en_o, evt_ready_o);
        end
        cyc();
    endtask

    task automatic test_same_addr();
        int s0, s1;
        wr_log.delete();
        threshold_i = 16'd10;
        send(4'd5, 8'd3, s0);
        send(4'd5, 8'd3, s1);
        idle(4);
        n_vec++;
        if (s0 != 0 || s1 != 1) begin
            n_err++;
            $display("FAIL same_addr_stall: got stalls %0d,%0d required 0,1", s0, s1);
        end
        n_vec++;
        if (wr_log.size() != 2 || wr_log[0].a !== 4'd5 || wr_log[0].d !== 16'd3
            || wr_log[1].a !== 4'd5 || wr_log[1].d !== 16'd6) begin
            n_err++;
            $display("FAIL same_addr_writes: got %0d writes required (5,3),(5,6)", wr_log.size());
        end
        n_vec++;
        if ({spk_valid_o, rd_en_o, wr_en_o, group_clk_en_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL same_addr_idle: got spk,rd,wr,gce=%b required 0000",
                     {spk_valid_o, rd_en_o, wr_en_o, group_clk_en_o});
        end
    endtask

    task automatic test_alternate();
        int s0, s1, s2;
        wr_log.delete();
        send(4'd4, 8'd1, s0);
        send(4'd5, 8'd1, s1);
        send(4'd6, 8'd1, s2);
        idle(3);
        n_vec++;
        if (s0 != 0 || s1 != 0 || s2 != 0) begin
            n_err++;
            $display("FAIL alt_stall: got stalls %0d,%0d,%0d required 0,0,0", s0, s1, s2);
        end
        n_vec++;
        if (wr_log.size() != 3) begin
            n_err++;
            $display("FAIL alt_count: got %0d writes required 3", wr_log.size());
        end else begin
            if (wr_log[0].a !== 4'd4 || wr_log[0].d !== 16'd1 || wr_log[1].a !== 4'd5
                || wr_log[1].d !== 16'd7 || wr_log[2].a !== 4'd6 || wr_log[2].d !== 16'd1) begin
                n_err++;
                $display("FAIL alt_data: got (%0d,%0d),(%0d,%0d),(%0d,%0d) required (4,1),(5,7),(6,1)",
                         wr_log[0].a, wr_log[0].d, wr_log[1].a, wr_log[1].d, wr_log[2].a, wr_log[2].d);
            end
            n_vec++;
            if (wr_log[1].c != wr_log[0].c + 1 || wr_log[2].c != wr_log[1].c + 1) begin
                n_err++;
                $display("FAIL alt_timing: got cycles %0d,%0d,%0d required consecutive",
                         wr_log[0].c, wr_log[1].c, wr_log[2].c);
            end
        end
    endtask

    task automatic test_spike();
        int s0, s1, s2;
        wr_log.delete();
        threshold_i = 16'd10;
        spk_ready_i = 1'b0;
        send(4'd2, 8'd6, s0);
        send(4'd2, 8'd6, s1);
        idle(2);
        n_vec++;
        if (wr_log.size() != 2 || wr_log[0].d !== 16'd6 || wr_log[1].a !== 4'd2 || wr_log[1].d !== 16'd0) begin
            n_err++;
            $display("FAIL spike_write: got %0d writes required (2,6),(2,0)", wr_log.size());
        end
        n_vec++;
        if (spk_valid_o !== 1'b1 || spk_addr_o !== 4'd2) begin
            n_err++;
            $display("FAIL spike_out: got valid=%b addr=%0d required 1 2", spk_valid_o, spk_addr_o);
        end
        send(4'd3, 8'd12, s2);
        evt_addr_i = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (evt_ready_o !== 1'b0 || wr_en_o !== 1'b0 || spk_addr_o !== 4'd2) begin
                n_err++;
                $display("FAIL spike_hold: got ready=%b wr_en=%b spk_addr=%0d required 0 0 2",
                         evt_ready_o, wr_en_o, spk_addr_o);
            end
            cyc();
        end
        spk_ready_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if (wr_en_o !== 1'b1 || wr_addr_o !== 4'd3 || wr_data_o !== 16'd0) begin
            n_err++;
            $display("FAIL spike_release_write: got en=%b addr=%0d data=%h required 1 3 0000",
                     wr_en_o, wr_addr_o, wr_data_o);
        end
        cyc();
        @(negedge clk);
        n_vec++;
        if (spk_valid_o !== 1'b1 || spk_addr_o !== 4'd3 || evt_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL spike_reload: got valid=%b addr=%0d ready=%b required 1 3 1",
                     spk_valid_o, spk_addr_o, evt_ready_o);
        end
        cyc();
        @(negedge clk);
        n_vec++;
        if (spk_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL spike_drain: got valid=%b required 0", spk_valid_o);
        end
        cyc();
    endtask

    task automatic test_saturate();
        int s0, s1;
        preload(4'd7, 16'h8000);
        preload(4'd8, 16'hFF9C);
        wr_log.delete();
        threshold_i = 16'd0;
        send(4'd7, 8'hFB, s0);
        send(4'd8, 8'hFB, s1);
        idle(3);
        n_vec++;
        if (wr_log.size() != 2 || wr_log[0].a !== 4'd7 || wr_log[0].d !== 16'h8000
            || wr_log[1].a !== 4'd8 || wr_log[1].d !== 16'hFF97) begin
            n_err++;
            $display("FAIL saturate_writes: got %0d writes required (7,8000),(8,ff97)", wr_log.size());
        end
        n_vec++;
        if (spk_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL saturate_nospike: got valid=%b required 0", spk_valid_o);
        end
    endtask

    task automatic test_reset_mid();
        int s0, s1;
        threshold_i = 16'd10;
        spk_ready_i = 1'b0;
        send(4'd11, 8'd127, s0);
        idle(2);
        send(4'd10, 8'd1, s1);
        rst_i = 1'b1;
        wr_log.delete();
        #1;
        n_vec++;
        if ({wr_en_o, rd_en_o, spk_valid_o, busy_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_mid: got wr,rd,spk,busy=%b required 0000",
                     {wr_en_o, rd_en_o, spk_valid_o, busy_o});
        end
        idle(2);
        rst_i = 1'b0;
        idle(3);
        n_vec++;
        if (wr_log.size() != 0 || spk_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_after: got %0d writes spk=%b required 0 0", wr_log.size(), spk_valid_o);
        end
    endtask

    initial begin
        rst_i        = 1'b1;
        clear_i      = 1'b0;
        threshold_i  = 16'd10;
        evt_valid_i  = 1'b0;
        evt_addr_i   = '0;
        evt_weight_i = '0;
        spk_ready_i  = 1'b1;
        #1;
        test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        test_clear();
        test_same_addr();
        test_alternate();
        test_spike();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/evt_state_update_lane.md
Name: evt_state_update_lane

Overview:
- One neuron-group lane that performs read-modify-write integration of synaptic events into the neuron state memory.
- Accepts events (neuron address plus signed weight) and reads the state word.
- Adds the weight with saturation, compares against the firing threshold, and writes back either the new state or zero on a spike.
- Emits spikes downstream. Sits directly upstream of the even/odd-banked status memory and drives one read port and one write port of that memory, plus its group clock enable.

Parameters:
- NEURONS_ADDR_WIDTH, 12, neuron address width; bit 0 selects the odd/even bank.
- STATE_DATA_WIDTH, 16, signed neuron state width.
- WEIGHT_WIDTH, 8, signed event weight width; must be <= STATE_DATA_WIDTH.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- clear_i  in  1  pulse; request zeroing of all 2**NEURONS_ADDR_WIDTH states
- busy_o  out  1  clear sweep pending or in progress
- threshold_i  in  STATE_DATA_WIDTH  signed firing threshold; quasi-static
- evt_valid_i  in  1  event valid
- evt_ready_o  out  1  event ready
- evt_addr_i  in  NEURONS_ADDR_WIDTH  target neuron
- evt_weight_i  in  WEIGHT_WIDTH  signed weight
- spk_valid_o  out  1  spike valid
- spk_ready_i  in  1  spike ready
- spk_addr_o  out  NEURONS_ADDR_WIDTH  spiking neuron
- rd_en_o  out  1  state read enable
- rd_addr_o  out  NEURONS_ADDR_WIDTH  state read address
- rd_data_i  in  STATE_DATA_WIDTH  read data, valid exactly 1 cycle after rd_en_o
- wr_en_o  out  1  state write enable
- wr_addr_o  out  NEURONS_ADDR_WIDTH  state write address
- wr_data_o  out  STATE_DATA_WIDTH  state write data
- group_clk_en_o  out  1  clock enable for this lane's memory group

Behaviour:
- Reset: FSM enters RUN. All valid and pending flags clear. Outputs are all 0 except evt_ready_o, which follows its equation (1 when evt_valid_i allows). Reset mid-operation drops in-flight events and any sweep without a memory write.
- FSM states:
  - RUN: normal event processing.
  - CLR_WAIT: clear requested while the pipeline is non-empty.
  - CLR: sweep counter runs 0..2**NAW-1, one write of 0 per cycle with wr_addr_o = counter.
- FSM transitions:
  - RUN -> CLR on clear_i when stage 1 is empty, otherwise RUN -> CLR_WAIT.
  - CLR_WAIT -> CLR when stage 1 empties.
  - CLR -> RUN after the write to the last address.
  - clear_i in CLR/CLR_WAIT is ignored.
- busy_o = 1 in CLR_WAIT/CLR. evt_ready_o = 0 in both. Sweep length is exactly 2**NAW cycles.
- Stage 0 (accept): handshake on evt_valid_i & evt_ready_o. The same cycle, rd_en_o = 1 and rd_addr_o = evt_addr_i (combinational). The address and weight are registered into stage 1.
- Stage 1 (update):
  - In its first cycle, state = rd_data_i, which is also captured into a hold register. Later stall cycles use the hold register.
  - sum = sat(state + sext(weight)), clamped to [-2**(SDW-1), 2**(SDW-1)-1].
  - fire = (sum >= threshold_i), signed comparison.
  - Commit condition: ~fire, or the spike register is empty, or spk_ready_i.
  - On commit: wr_en_o = 1, wr_addr_o = stage-1 address, wr_data_o = fire ? 0 : sum. If fire, the spike register loads the address.
- Spike register: single entry, holds until spk_valid_o & spk_ready_i. It may be loaded in the same cycle it drains.
- Bank hazard: the memory suppresses a read to a bank written in the same cycle. Therefore evt_ready_o = 0 when:
  - stage 1 is valid and evt_addr_i[0] == stage-1 address[0], or
  - stage 1 is stalled.
  
  A same-address event therefore always stalls exactly 1 cycle and reads the freshly written value. No forwarding path exists.
- Throughput: 1 event/cycle when consecutive events alternate banks. Latency from accept to write is 1 cycle; to spk_valid_o is 2 cycles.
- group_clk_en_o = rd_en_o | wr_en_o | stage-1 valid.
- Pipeline state with evt_valid_i low: the pipeline drains, then all memory enables are 0.

Decomposition:
- Shared package sne_evt_stream_pkg holds:
  - typedef state_t (signed [STATE_DATA_WIDTH-1:0]);
  - typedef lane_fsm_e {RUN, CLR_WAIT, CLR};
  - a sat_add function (state + sign-extended weight, clamped).
- One natural sub-module: evt_sat_add_cmp, the combinational saturating add plus threshold compare. Everything else stays flat.

Test Plan:
- Reset asserted mid-event (stage 1 valid): wr_en_o, rd_en_o, spk_valid_o, busy_o = 0 immediately; no write occurs after release.
- NAW=4, clear_i pulse in RUN with empty pipeline: busy_o high 16 cycles, wr_en_o on addr 0..15 with data 0, then returns to RUN.
- Events (5,+3), (5,+3) back-to-back after clear: second event sees evt_ready_o = 0 for 1 cycle; writes 3 then 6; no spike with threshold 10.
- Events (4,+1), (5,+1), (6,+1) on consecutive cycles: accepted every cycle with no stall; writes addr 4, 5, 6 on consecutive cycles.
- threshold 10, events (2,+6), (2,+6) with spk_ready_i = 0: second event writes 0 to addr 2 and spk_valid_o = 1, spk_addr_o = 2. A third firing event to addr 3 holds stage 1 and evt_ready_o stays 0 until spk_ready_i = 1.
- State -32768 at addr 7, event weight -5, threshold 0: writes -32768 (saturated), no spike.
